// File: rtl/control_unit_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer producing datapath
// strobes, ALU selects, overflow write suppression and a retired-instruction counter.
module control_unit_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opcode,
    input  logic        Zero,
    input  logic        Negative,
    input  logic        Overflow,
    output logic        pc_load,
    output logic        write_en,
    output logic        CS,
    output logic        OE,
    output logic        RW_,
    output logic        rd_sel,
    output logic        rt_sel,
    output logic        data_in_sel,
    output logic        branch,
    output logic        jump,
    output logic [3:0]  alu_opcode,
    output logic        halted,
    output logic        ovf_sticky,
    output logic [2:0]  state,
    output logic [15:0] retired_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BLT  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  op_q;
    logic        ovf_q;
    logic        sticky_q;
    logic [15:0] count_q;
    logic        count_inc;

    logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_blt, is_jmp, is_ovf_op, is_flow;

    assign is_rtype  = (op_q <= 4'd6);
    assign is_addi   = (op_q == OP_ADDI);
    assign is_lw     = (op_q == OP_LW);
    assign is_sw     = (op_q == OP_SW);
    assign is_beq    = (op_q == OP_BEQ);
    assign is_blt    = (op_q == OP_BLT);
    assign is_jmp    = (op_q == OP_JMP);
    assign is_ovf_op = (op_q == 4'd0) || (op_q == 4'd1) || is_addi;
    // Branch, jump and NOP retire straight out of EXEC.
    assign is_flow   = (op_q >= OP_BEQ);

    // All outputs are gated by reset so no strobe fires in a reset cycle.
    always_comb begin
        state_d     = S_FETCH;
        count_inc   = 1'b0;
        pc_load     = 1'b0;
        write_en    = 1'b0;
        CS          = 1'b0;
        OE          = 1'b0;
        RW_         = 1'b1;
        rd_sel      = 1'b0;
        rt_sel      = 1'b0;
        data_in_sel = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        alu_opcode  = 4'd0;
        if (!reset) begin
            OE = (state_q != S_HALT);
            if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
                rd_sel      = is_rtype;
                rt_sel      = is_addi || is_lw || is_sw;
                data_in_sel = !is_lw;
                if (is_rtype)
                    alu_opcode = op_q;
                else if (is_beq || is_blt)
                    alu_opcode = 4'd1;
            end
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    // The HALT decision uses the live opcode; op_q is loaded on this edge.
                    if (opcode == OP_HALT) begin
                        state_d   = S_HALT;
                        count_inc = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    branch = (is_beq && Zero) || (is_blt && Negative);
                    jump   = is_jmp;
                    if (is_rtype || is_addi)
                        state_d = S_WB;
                    else if (is_lw || is_sw)
                        state_d = S_MEM;
                    else begin
                        state_d = S_FETCH;
                        pc_load = is_flow;
                    end
                end
                S_MEM: begin
                    CS  = is_lw || is_sw;
                    RW_ = !is_sw;
                    if (is_lw)
                        state_d = S_WB;
                    else begin
                        state_d = S_FETCH;
                        pc_load = is_sw;
                    end
                end
                S_WB: begin
                    CS       = is_lw;
                    write_en = !ovf_q;
                    pc_load  = 1'b1;
                    state_d  = S_FETCH;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
            if (pc_load)
                count_inc = 1'b1;
        end
        state         = reset ? S_FETCH : state_q;
        halted        = !reset && (state_q == S_HALT);
        ovf_sticky    = !reset && sticky_q;
        retired_count = reset ? 16'd0 : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            op_q     <= 4'd0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= opcode;
            if (state_q == S_EXEC)
                ovf_q <= is_ovf_op && Overflow;
            if (state_q == S_WB && ovf_q)
                sticky_q <= 1'b1;
            if (count_inc)
                count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: doc/control_unit_fsm.md
CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: opcode  in  4  instruction bits [15:12] from instruction memory.
REQ-004 SHALL have ports: Zero, Negative, Overflow  in  1 each  combinational ALU flags.
REQ-005 SHALL have ports: pc_load, write_en, CS, OE  out  1 each  datapath strobes; RW_  out  1  1=read, 0=write.
REQ-006 SHALL have ports: rd_sel, rt_sel, data_in_sel, branch, jump  out  1 each.
- rd_sel: 0=IR[7:4], 1=IR[3:0].
- rt_sel: 0=register rt, 1=sign-extended IR[3:0].
- data_in_sel: 0=data memory, 1=ALU.
REQ-007 SHALL have port: alu_opcode  out  4  ALU operation code.
REQ-008 SHALL have ports: halted  out  1; ovf_sticky  out  1; state  out  3; retired_count  out  16.

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; encodings 6-7 SHALL go to FETCH next cycle.
REQ-010 SHALL latch opcode into an internal register in DECODE; all decode-dependent outputs SHALL use the latched value.
REQ-011 SHALL use this opcode map:
- 0-6 R-type ADD,SUB,AND,OR,XOR,SLL,SRL.
- 7 ADDI; 8 LW; 9 SW.
- A BEQ (taken if Zero); B BLT (taken if Negative).
- C JMP; D HALT; E-F NOP.
REQ-012 SHALL sequence transitions:
- FETCH->DECODE always.
- DECODE->HALT for HALT, else EXEC.
- EXEC->WB for R-type/ADDI; EXEC->MEM for LW/SW; EXEC->FETCH for branch/JMP/NOP.
- MEM->WB for LW; MEM->FETCH for SW.
- WB->FETCH always.
- HALT->HALT until reset.
REQ-013 SHALL set alu_opcode as follows, else 0:
- R-type: latched opcode.
- ADDI/LW/SW: 0 (ADD).
- BEQ/BLT: 1 (SUB).
REQ-014 SHALL assert rd_sel=1 for R-type, 0 otherwise; rt_sel=1 for ADDI/LW/SW, 0 otherwise.
REQ-015 SHALL assert data_in_sel=0 for LW, 1 otherwise.
REQ-016 SHALL hold rd_sel, rt_sel, data_in_sel and alu_opcode at 0 in FETCH and HALT.
REQ-017 SHALL drive OE=1 in every state except HALT.
REQ-018 SHALL drive RW_=1 except RW_=0 in MEM for SW.
REQ-019 SHALL drive CS=1 in MEM for LW/SW and in WB for LW, else 0.
REQ-020 SHALL register Overflow in EXEC for ADD/SUB/ADDI as ovf_q, and clear ovf_q in EXEC for all other opcodes.
REQ-021 SHALL assert write_en for exactly one cycle in WB, except when ovf_q=1, which suppresses the write.
REQ-022 SHALL set ovf_sticky=1 on a suppressed write; ovf_sticky SHALL clear only on reset.
REQ-023 SHALL assert pc_load for exactly one cycle per non-HALT instruction:
- in WB for R-type/ADDI/LW;
- in MEM for SW;
- in EXEC for branch/JMP/NOP.
REQ-024 SHALL assert branch only in EXEC, and only for BEQ with Zero=1 or BLT with Negative=1 (live flags); jump SHALL be 1 only in EXEC for JMP.
REQ-025 SHALL increment retired_count on each pc_load and on the DECODE->HALT transition; 0xFFFF SHALL wrap to 0x0000.
REQ-026 SHALL drive halted=1 exactly while state==HALT.
REQ-027 Per-instruction latency SHALL be:
- 3 cycles for branch/JMP/NOP;
- 4 cycles for R-type/ADDI/SW;
- 5 cycles for LW.

Reset
REQ-028 While reset=1, SHALL force state=FETCH and outputs:
- pc_load=write_en=CS=OE=branch=jump=0, RW_=1;
- all selects and alu_opcode 0;
- ovf_sticky=0, retired_count=0, latched opcode=0, ovf_q=0.
REQ-029 Reset asserted in any state, including mid-instruction and HALT, SHALL take effect at the next edge; no strobe SHALL fire in that cycle.
REQ-030 After reset deasserts, the first cycle SHALL be FETCH with OE=1.

Verification
REQ-031 ADD (opcode 0), Overflow=0 -> states 0,1,2,4; write_en and pc_load both 1 in WB only; rd_sel=1; alu_opcode=0; retired_count=1.
REQ-032 LW (8) -> states 0,1,2,3,4; CS=1 in MEM and WB; RW_=1; data_in_sel=0; rt_sel=1; pc_load in WB; 5 cycles.
REQ-033 SW (9) -> MEM cycle has CS=1, RW_=0, pc_load=1; write_en never asserted; returns to FETCH after 4 cycles.
REQ-034 BEQ (A): Zero=1 -> EXEC branch=1, pc_load=1, alu_opcode=1; Zero=0 -> branch=0, pc_load=1. JMP (C) -> jump=1 in EXEC.
REQ-035 ADDI (7) with Overflow=1 in EXEC -> WB write_en=0, pc_load=1, ovf_sticky=1 and held through later instructions.
REQ-036 HALT (D) -> halted=1, OE=0, retired_count+1, no pc_load for 20 cycles; reset pulse mid-HALT -> FETCH, retired_count=0.
